mvb_frame_encoder: RTL and testbench

- Single-clock MVB frame encoder. Buffers DATA_W-bit words in an internal FIFO and serialises master or slave frames onto the line: start delimiter, Manchester-coded data, an 8-bit check sequence per data group, then the end delimiter.
- Successor to the multi-clock encoder top. Adds:
  - clock-enable timing derived from one clock;
  - parametrised word width and FIFO depth;
  - slave frames of 1/2/4/8/16 words with a check sequence inserted every 64 bits;
  - length and underrun checks before transmission.
- Sits between the frame builder (FIFO writer) and the line driver.

---
 rtl/mvb_enc_pkg.sv | 31 +++
 rtl/mvb_crc7p.sv | 36 +++
 rtl/mvb_frame_encoder.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mvb_frame_encoder.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mvb_enc_pkg.sv
// Shared types and constants for the MVB frame encoder.
package mvb_enc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SD,
    ST_DATA,
    ST_CRC,
    ST_ED,
    ST_DONE
  } state_t;

  typedef enum logic {
    FT_MASTER = 1'b0,
    FT_SLAVE  = 1'b1
  } frame_type_t;

  localparam logic [17:0] SD_MASTER = 18'b10_11_00_01_11_00_10_10_10;
  localparam logic [17:0] SD_SLAVE  = 18'b10_10_10_10_00_11_01_00_11;
  localparam logic [3:0]  ED        = 4'b1100;

  // x^7 + x^6 + x^5 + x^2 + 1, x^7 term implicit
  localparam logic [6:0]  CRC_POLY  = 7'h65;

  // Slave frames carry 1, 2, 4, 8 or 16 words, capped by the instance limit
  function automatic logic legal_len(input int unsigned words, input int unsigned max_words);
    return ((words == 1) || (words == 2) || (words == 4) || (words == 8) || (words == 16)) &&
           (words <= max_words);
  endfunction

endpackage

// File: rtl/mvb_crc7p.sv
// Bit-serial CRC-7 with trailing even parity; emits the inverted check byte MSB first.
module mvb_crc7p import mvb_enc_pkg::*; (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_shift,
  input  logic i_bit,
  input  logic i_shift_out,
  input  logic i_par_sel,
  output logic o_chk
);

  logic [6:0] r_crc;
  logic       r_par;
  logic       w_fb;

  assign w_fb = r_crc[6] ^ i_bit;

  // Data bits update CRC and parity; shift-out folds each CRC bit into the parity
  // so that after seven shifts r_par holds parity over group bits plus CRC.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_crc <= '0;
      r_par <= 1'b0;
    end else if (i_shift) begin
      r_crc <= {r_crc[5:0], 1'b0} ^ (w_fb ? CRC_POLY : 7'b0);
      r_par <= r_par ^ i_bit;
    end else if (i_shift_out) begin
      r_crc <= {r_crc[5:0], 1'b0};
      r_par <= r_par ^ r_crc[6];
    end
  end

  assign o_chk = ~(i_par_sel ? r_par : r_crc[6]);

endmodule

// File: rtl/mvb_frame_encoder.sv
// MVB frame encoder: word FIFO plus SD / Manchester data / check byte / ED serialiser.
module mvb_frame_encoder import mvb_enc_pkg::*; #(
  parameter int unsigned DATA_W        = 16,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned CLKS_PER_HALF = 8,
  parameter int unsigned MAX_WORDS     = 16,
  parameter int unsigned GROUP_BITS    = 64
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               wr_en,
  input  logic [DATA_W-1:0]                  wr_data,
  output logic                               fifo_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               wr_ovf,
  input  logic                               send_frame,
  input  logic                               frame_type,
  input  logic [$clog2(MAX_WORDS+1)-1:0]     frame_words,
  output logic                               busy,
  output logic                               len_err,
  output logic                               underrun_err,
  output logic                               frame_over,
  output logic                               tx_en,
  output logic                               line_out
);

  localparam int unsigned LVL_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned FW_W   = $clog2(MAX_WORDS + 1);
  localparam int unsigned TICK_W = (CLKS_PER_HALF > 1) ? $clog2(CLKS_PER_HALF) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int unsigned GRP_W  = (GROUP_BITS > 1) ? $clog2(GROUP_BITS) : 1;

  // ---------------- FIFO ----------------
  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr, r_rd_ptr;
  logic [LVL_W-1:0]  r_level;
  logic              r_wr_ovf;
  logic              w_full, w_push, w_pop;
  logic [DATA_W-1:0] w_head;

  assign w_full = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push = wr_en && !w_full;
  assign w_head = r_mem[r_rd_ptr];

  // Storage array, written only on accepted pushes
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  // FIFO pointers, level and overflow pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_wr_ovf <= 1'b0;
    end else begin
      r_wr_ovf <= wr_en && w_full;
      if (w_push) r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  assign fifo_full  = w_full;
  assign fifo_level = r_level;
  assign wr_ovf     = r_wr_ovf;

  // ---------------- Serialiser ----------------
  state_t              r_state;
  logic [TICK_W-1:0]   r_tick;
  logic [4:0]          r_hcnt;
  logic [17:0]         r_sym;
  logic [DATA_W-1:0]   r_shreg;
  logic [BIT_W-1:0]    r_bitcnt;
  logic [GRP_W-1:0]    r_grp;
  logic [FW_W-1:0]     r_words_left;
  logic                r_half, r_last_grp;
  logic                r_busy, r_tx_en, r_line, r_frame_over, r_len_err, r_und_err;

  logic [FW_W-1:0]     w_need;
  logic                w_len_bad, w_under, w_accept;
  logic                w_he, w_word_end, w_frame_end, w_grp_end;
  logic                w_crc_clear, w_crc_shift, w_crc_shout, w_par_sel, w_chk;

  assign w_need    = (frame_type == FT_SLAVE) ? frame_words : FW_W'(1);
  assign w_len_bad = (frame_type == FT_SLAVE) && !legal_len(32'(frame_words), MAX_WORDS);
  assign w_under   = 32'(r_level) < 32'(w_need);
  assign w_accept  = (r_state == ST_IDLE) && send_frame && !w_len_bad && !w_under;

  // Word/group counters have already advanced when the second half-bit ends,
  // so a wrapped counter marks the end of a word or group.
  assign w_he        = (r_tick == TICK_W'(CLKS_PER_HALF - 1));
  assign w_word_end  = (r_bitcnt == '0);
  assign w_frame_end = w_word_end && (r_words_left == FW_W'(1));
  assign w_grp_end   = (r_grp == '0);

  // FIFO pop and CRC controls, aligned with the half-bit boundaries of the FSM
  always_comb begin
    w_pop       = 1'b0;
    w_crc_clear = w_accept;
    w_crc_shift = 1'b0;
    w_crc_shout = 1'b0;
    w_par_sel   = (r_state == ST_CRC) && (r_hcnt[3:1] == 3'd6);
    unique case (r_state)
      ST_SD:   w_pop = w_he && (r_hcnt == 5'd17);
      ST_DATA: begin
        w_pop       = w_he && r_half && w_word_end && !w_frame_end && !w_grp_end;
        w_crc_shift = w_he && !r_half;
      end
      ST_CRC: begin
        w_pop       = w_he && (r_hcnt == 5'd15) && !r_last_grp && w_word_end;
        w_crc_shout = w_he && !r_hcnt[0];
        w_crc_clear = w_he && (r_hcnt == 5'd15);
      end
      default: ;
    endcase
  end

  mvb_crc7p u_crc (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_crc_clear),
    .i_shift     (w_crc_shift),
    .i_bit       (r_shreg[DATA_W-1]),
    .i_shift_out (w_crc_shout),
    .i_par_sel   (w_par_sel),
    .o_chk       (w_chk)
  );

  // Frame FSM; every output is registered and the next half-bit level is
  // loaded on the last cycle of the current one.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_tick       <= '0;
      r_hcnt       <= '0;
      r_sym        <= '0;
      r_shreg      <= '0;
      r_bitcnt     <= '0;
      r_grp        <= '0;
      r_words_left <= '0;
      r_half       <= 1'b0;
      r_last_grp   <= 1'b0;
      r_busy       <= 1'b0;
      r_tx_en      <= 1'b0;
      r_line       <= 1'b0;
      r_frame_over <= 1'b0;
      r_len_err    <= 1'b0;
      r_und_err    <= 1'b0;
    end else begin
      r_frame_over <= 1'b0;
      r_len_err    <= 1'b0;
      r_und_err    <= 1'b0;
      if ((r_state != ST_IDLE) && (r_state != ST_DONE))
        r_tick <= w_he ? '0 : r_tick + 1'b1;

      unique case (r_state)
        ST_IDLE: begin
          if (send_frame) begin
            if (w_len_bad)     r_len_err <= 1'b1;
            else if (w_under)  r_und_err <= 1'b1;
            else begin
              r_state      <= ST_SD;
              r_busy       <= 1'b1;
              r_tx_en      <= 1'b1;
              r_tick       <= '0;
              r_hcnt       <= '0;
              r_words_left <= w_need;
              r_bitcnt     <= '0;
              r_grp        <= '0;
              if (frame_type == FT_SLAVE) begin
                r_line <= SD_SLAVE[17];
                r_sym  <= {SD_SLAVE[16:0], 1'b0};
              end else begin
                r_line <= SD_MASTER[17];
                r_sym  <= {SD_MASTER[16:0], 1'b0};
              end
            end
          end
        end

        ST_SD: begin
          if (w_he) begin
            if (r_hcnt == 5'd17) begin
              r_state <= ST_DATA;
              r_hcnt  <= '0;
              r_half  <= 1'b0;
              r_shreg <= w_head;
              r_line  <= w_head[DATA_W-1];
            end else begin
              r_line <= r_sym[17];
              r_sym  <= {r_sym[16:0], 1'b0};
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end

        ST_DATA: begin
          if (w_he) begin
            if (!r_half) begin
              r_half   <= 1'b1;
              r_line   <= ~r_line;
              r_shreg  <= {r_shreg[DATA_W-2:0], 1'b0};
              r_bitcnt <= (r_bitcnt == BIT_W'(DATA_W - 1))     ? '0 : r_bitcnt + 1'b1;
              r_grp    <= (r_grp    == GRP_W'(GROUP_BITS - 1)) ? '0 : r_grp + 1'b1;
            end else begin
              r_half <= 1'b0;
              if (w_grp_end || w_frame_end) begin
                // A word that ends with its group is fetched after the check byte
                r_state    <= ST_CRC;
                r_hcnt     <= '0;
                r_line     <= w_chk;
                r_last_grp <= w_frame_end;
                if (w_word_end && !w_frame_end) r_words_left <= r_words_left - 1'b1;
              end else if (w_word_end) begin
                r_shreg      <= w_head;
                r_line       <= w_head[DATA_W-1];
                r_words_left <= r_words_left - 1'b1;
              end else begin
                r_line <= r_shreg[DATA_W-1];
              end
            end
          end
        end

        ST_CRC: begin
          if (w_he) begin
            if (!r_hcnt[0]) begin
              r_line <= ~r_line;
              r_hcnt <= r_hcnt + 1'b1;
            end else if (r_hcnt == 5'd15) begin
              r_hcnt <= '0;
              if (r_last_grp) begin
                r_state <= ST_ED;
                r_line  <= ED[3];
                r_sym   <= {ED[2:0], 15'b0};
              end else begin
                r_state <= ST_DATA;
                r_half  <= 1'b0;
                if (w_word_end) begin
                  r_shreg <= w_head;
                  r_line  <= w_head[DATA_W-1];
                end else begin
                  r_line <= r_shreg[DATA_W-1];
                end
              end
            end else begin
              r_line <= w_chk;
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end

        ST_ED: begin
          if (w_he) begin
            if (r_hcnt == 5'd3) begin
              r_state      <= ST_DONE;
              r_tx_en      <= 1'b0;
              r_busy       <= 1'b0;
              r_line       <= 1'b0;
              r_frame_over <= 1'b1;
            end else begin
              r_line <= r_sym[17];
              r_sym  <= {r_sym[16:0], 1'b0};
              r_hcnt <= r_hcnt + 1'b1;
            end
          end
        end

        ST_DONE: r_state <= ST_IDLE;

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy         = r_busy;
  assign tx_en        = r_tx_en;
  assign line_out     = r_line;
  assign frame_over   = r_frame_over;
  assign len_err      = r_len_err;
  assign underrun_err = r_und_err;

endmodule

// File: tb/tb_mvb_frame_encoder.sv
// Scoreboard bench for mvb_frame_encoder: requests queue expected line waveforms,
// a negedge monitor collects each tx_en burst and compares it.
module tb_mvb_frame_encoder;

  localparam int DW    = 16;
  localparam int DEPTH = 16;
  localparam int CPH   = 8;
  localparam int MAXW  = 16;
  localparam int GB    = 64;

  logic          clk = 1'b0;
  logic          rst, wr_en, send_frame, frame_type;
  logic [DW-1:0] wr_data;
  logic [4:0]    frame_words;
  logic          fifo_full, wr_ovf, busy, len_err, underrun_err, frame_over, tx_en, line_out;
  logic [4:0]    fifo_level;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int len;
    bit abort;
  } desc_t;

  logic [DW-1:0] mdl_fifo[$];
  bit            exp_line[$];
  desc_t         sb[$];
  bit            act[$];
  bit            prev_tx = 1'b0;
  int            fo_during = 0;

  mvb_frame_encoder #(
    .DATA_W        (DW),
    .FIFO_DEPTH    (DEPTH),
    .CLKS_PER_HALF (CPH),
    .MAX_WORDS     (MAXW),
    .GROUP_BITS    (GB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .fifo_full    (fifo_full),
    .fifo_level   (fifo_level),
    .wr_ovf       (wr_ovf),
    .send_frame   (send_frame),
    .frame_type   (frame_type),
    .frame_words  (frame_words),
    .busy         (busy),
    .len_err      (len_err),
    .underrun_err (underrun_err),
    .frame_over   (frame_over),
    .tx_en        (tx_en),
    .line_out     (line_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected frame: SD, Manchester data with inverted CRC-7+parity byte per group, ED
  task automatic build_frame(input bit ft, input int need, input bit abort);
    logic [17:0]   sd;
    logic [DW-1:0] w;
    logic [6:0]    c;
    logic [7:0]    chk;
    bit            p, fb;
    bit            hb[$];
    bit            bits[$];
    sd = ft ? 18'b10_10_10_10_00_11_01_00_11 : 18'b10_11_00_01_11_00_10_10_10;
    for (int i = 17; i >= 0; i--) hb.push_back(sd[i]);
    repeat (need) begin
      w = mdl_fifo.pop_front();
      for (int i = DW - 1; i >= 0; i--) bits.push_back(w[i]);
    end
    for (int g = 0; g < bits.size(); g += GB) begin
      c = '0;
      p = 1'b0;
      for (int k = g; (k < g + GB) && (k < bits.size()); k++) begin
        hb.push_back(bits[k]);
        hb.push_back(!bits[k]);
        fb = c[6] ^ bits[k];
        c  = {c[5:0], 1'b0};
        if (fb) c = c ^ 7'b1100101;
        p  = p ^ bits[k];
      end
      p   = p ^ (^c);
      chk = ~{c, p};
      for (int i = 7; i >= 0; i--) begin
        hb.push_back(chk[i]);
        hb.push_back(!chk[i]);
      end
    end
    hb.push_back(1'b1); hb.push_back(1'b1); hb.push_back(1'b0); hb.push_back(1'b0);
    foreach (hb[i]) repeat (CPH) exp_line.push_back(hb[i]);
    sb.push_back('{len: hb.size() * CPH, abort: abort});
  endtask

  task automatic finish_frame();
    desc_t d;
    int    errs;
    bit    e;
    if (sb.size() == 0) begin
      check("unexpected_frame_cycles", act.size(), 0);
    end else begin
      d    = sb.pop_front();
      errs = 0;
      for (int i = 0; i < d.len; i++) begin
        e = exp_line.pop_front();
        if ((i < act.size()) && (act[i] != e)) errs++;
      end
      if (d.abort) check("abort_cut_short", act.size() < d.len, 1);
      else         check("frame_tx_en_cycles", act.size(), d.len);
      check("frame_halfbit_errors", errs, 0);
      check("frame_over_at_end", frame_over, d.abort ? 0 : 1);
      check("frame_over_inside_frame", fo_during, 0);
    end
    act.delete();
    fo_during = 0;
  endtask

  // Monitor: gather line samples while tx_en is high, score on its falling edge
  always @(negedge clk) begin
    if (tx_en === 1'b1) begin
      act.push_back(line_out);
      if (frame_over !== 1'b0) fo_during++;
    end else if (prev_tx) begin
      finish_frame();
    end
    prev_tx = (tx_en === 1'b1);
  end

  task automatic push_word(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    tick();
    wr_en   = 1'b0;
    if (mdl_fifo.size() < DEPTH) mdl_fifo.push_back(w);
  endtask

  task automatic request(input bit ft, input int n, input bit abort);
    int need;
    bit el, eu;
    need = ft ? n : 1;
    el   = ft && !(((n == 1) || (n == 2) || (n == 4) || (n == 8) || (n == 16)) && (n <= MAXW));
    eu   = !el && (mdl_fifo.size() < need);
    if (!el && !eu) build_frame(ft, need, abort);
    send_frame  = 1'b1;
    frame_type  = ft;
    frame_words = 5'(n);
    tick();
    send_frame  = 1'b0;
    check("len_err", len_err, el);
    check("underrun_err", underrun_err, eu);
    if (!el && !eu) begin
      check("busy_on_accept", busy, 1);
      check("tx_en_on_accept", tx_en, 1);
      check("first_sd_halfbit", line_out, 1);
    end else begin
      check("tx_en_after_reject", tx_en, 0);
      check("fifo_level_after_reject", fifo_level, mdl_fifo.size());
    end
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (((sb.size() != 0) || (tx_en === 1'b1)) && (k < budget)) begin
      tick();
      k++;
    end
    check("frame_done_within_budget", k < budget, 1);
    repeat (2) tick();
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int fo;
    rst = 1'b1; wr_en = 1'b0; wr_data = '0; send_frame = 1'b0; frame_type = 1'b0; frame_words = '0;
    repeat (3) tick();
    check("rst_tx_en", tx_en, 0);
    check("rst_line_out", line_out, 0);
    check("rst_busy", busy, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_frame_over", frame_over, 0);
    rst = 1'b0;
    tick();

    // Master frame of one zero word; frame_words is ignored for masters
    push_word(16'h0000);
    check("level_after_push", fifo_level, 1);
    request(1'b0, 5, 1'b0);
    wait_done(2000);
    check("level_after_master", fifo_level, 0);

    // Eight-word slave frame: two check groups
    push_word(16'hA5C3); push_word(16'h0001); push_word(16'hFFFF); push_word(16'h1234);
    push_word(16'h8000); push_word(16'h7FFE); push_word(16'hDEAD); push_word(16'hBEEF);
    request(1'b1, 8, 1'b0);
    wait_done(4000);

    // Length and underrun rejection, then a frame that exactly drains the FIFO
    push_word(16'h0F0F); push_word(16'hF0F0);
    request(1'b1, 3, 1'b0);
    request(1'b1, 0, 1'b0);
    request(1'b1, 4, 1'b0);
    push_word(16'h5555); push_word(16'hAAAA);
    request(1'b1, 4, 1'b0);
    tick();
    send_frame = 1'b1; frame_type = 1'b1; frame_words = 5'd3;
    tick();
    send_frame = 1'b0;
    check("busy_request_no_len_err", len_err, 0);
    check("busy_request_no_underrun", underrun_err, 0);
    wait_done(3000);

    // Master request against an empty FIFO
    request(1'b0, 1, 1'b0);

    // Fill to full and overflow
    for (int i = 0; i < 16; i++) begin
      push_word(16'h1000 + 16'(i * 16'h0111));
      if (i == 14) check("not_full_at_15", fifo_full, 0);
    end
    check("full_at_16", fifo_full, 1);
    check("level_at_16", fifo_level, 16);
    push_word(16'hBAD0);
    check("wr_ovf_on_17th", wr_ovf, 1);
    check("level_after_ovf", fifo_level, 16);
    tick();
    check("wr_ovf_one_cycle", wr_ovf, 0);

    // Largest slave frame; a write lands on the pop that ends the first word
    request(1'b1, 16, 1'b0);
    repeat (399) tick();
    push_word(16'h6C3A);
    check("level_push_and_pop", fifo_level, 15);
    check("no_ovf_push_and_pop", wr_ovf, 0);
    wait_done(8000);
    check("level_after_16_word_frame", fifo_level, 1);
    request(1'b0, 0, 1'b0);
    wait_done(2000);

    // Reset in the middle of a master frame
    push_word(16'hC0DE); push_word(16'h1357);
    request(1'b0, 1, 1'b1);
    repeat (199) tick();
    rst = 1'b1;
    tick();
    mdl_fifo.delete();
    check("abort_tx_en", tx_en, 0);
    check("abort_line_out", line_out, 0);
    check("abort_fifo_level", fifo_level, 0);
    check("abort_busy", busy, 0);
    rst = 1'b0;
    fo = 0;
    repeat (20) begin
      tick();
      if (frame_over !== 1'b0) fo++;
    end
    check("no_frame_over_after_abort", fo, 0);
    push_word(16'h00FF);
    request(1'b0, 1, 1'b0);
    wait_done(2000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
